ysyx_25020047_wb_stage: RTL and testbench



---
 rtl/ysyx_25020047_wb_stage.sv | 154 +++++++++++++++
 tb/tb_ysyx_25020047_wb_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_wb_stage.sv
// Registered writeback stage: source select, load alignment/extension,
// next-PC select, retire counting and sticky load-error flag.
module ysyx_25020047_wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_sel,
  input  logic              pc_sel,
  input  logic [2:0]        ld_fmt,
  input  logic [2:0]        ld_addr,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   result,
  input  logic [XLEN-1:0]   memdata,
  input  logic [XLEN-1:0]   snpc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [XLEN-1:0]   dnpc,
  output logic              ld_err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [2:0] AMASK = (XLEN == 64) ? 3'b111 : 3'b011;
  localparam bit IS64 = (XLEN == 64);

  logic [2:0]      lo;
  logic [5:0]      shamt;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] sw;
  logic [XLEN-1:0] zw;
  logic [XLEN-1:0] ld_data;
  logic            mis;
  logic            ill;
  logic            bad;
  logic [XLEN-1:0] wdata_d;
  logic            intent_d;
  logic            intent_q;
  logic            fire_in;
  logic            fire_out;

  assign lo    = ld_addr & AMASK;
  assign shamt = {lo, 3'b000};
  assign sh    = memdata >> shamt;

  // Word-sized extension only differs from the raw lane on RV64.
  generate
    if (XLEN == 64) begin : g_w64
      assign sw = {{(XLEN-32){sh[31]}}, sh[31:0]};
      assign zw = {{(XLEN-32){1'b0}}, sh[31:0]};
    end else begin : g_w32
      assign sw = sh;
      assign zw = sh;
    end
  endgenerate

  always_comb begin
    ld_data = sh;
    unique case (ld_fmt)
      3'b000:  ld_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  ld_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  ld_data = sw;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  ld_data = zw;
      default: ld_data = sh;
    endcase
  end

  always_comb begin
    mis = 1'b0;
    ill = 1'b0;
    unique case (ld_fmt)
      3'b001, 3'b101: mis = lo[0];
      3'b010:         mis = (lo[1:0] != 2'b00);
      3'b110: begin
        mis = (lo[1:0] != 2'b00);
        ill = !IS64;
      end
      3'b011: begin
        mis = (lo != 3'b000);
        ill = !IS64;
      end
      3'b111:  ill = 1'b1;
      default: mis = 1'b0;
    endcase
  end

  assign bad = (wb_sel == 2'd2) && (mis || ill);

  always_comb begin
    wdata_d  = '0;
    intent_d = 1'b0;
    unique case (1'b1)
      (wb_sel == 2'd1): begin
        wdata_d  = result;
        intent_d = 1'b1;
      end
      (wb_sel == 2'd2): begin
        wdata_d  = ld_data;
        intent_d = !bad;
      end
      (wb_sel == 2'd3): begin
        wdata_d  = snpc;
        intent_d = 1'b1;
      end
      default: begin
        wdata_d  = '0;
        intent_d = 1'b0;
      end
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      dnpc      <= '0;
      intent_q  <= 1'b0;
      ld_err    <= 1'b0;
      retired   <= '0;
    end else begin
      if (fire_in) begin
        out_valid <= 1'b1;
        rf_waddr  <= rd;
        rf_wdata  <= wdata_d;
        dnpc      <= pc_sel ? result : snpc;
        intent_q  <= intent_d;
      end else if (fire_out) begin
        out_valid <= 1'b0;
      end
      if (fire_in && bad) begin
        ld_err <= 1'b1;
      end
      if (fire_out) begin
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rf_wen = fire_out && intent_q && (rf_waddr != '0);

endmodule

// File: tb/tb_ysyx_25020047_wb_stage.sv
// Directed bench for the writeback stage (RV32 datapath plus a
// 4-bit retire-counter instance sharing the same stimulus).
module tb_ysyx_25020047_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic        pc_sel;
  logic [2:0]  ld_fmt;
  logic [2:0]  ld_addr;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] memdata;
  logic [31:0] snpc;
  logic        out_valid;
  logic        out_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] dnpc;
  logic        ld_err;
  logic [31:0] retired;

  logic        in_ready4;
  logic        out_valid4;
  logic        rf_wen4;
  logic [4:0]  rf_waddr4;
  logic [31:0] rf_wdata4;
  logic [31:0] dnpc4;
  logic        ld_err4;
  logic [3:0]  retired4;

  int checks;
  int failures;

  ysyx_25020047_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .pc_sel(pc_sel), .ld_fmt(ld_fmt),
    .ld_addr(ld_addr), .rd(rd), .result(result), .memdata(memdata),
    .snpc(snpc), .out_valid(out_valid), .out_ready(out_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dnpc(dnpc), .ld_err(ld_err), .retired(retired)
  );

  ysyx_25020047_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .wb_sel(wb_sel), .pc_sel(pc_sel), .ld_fmt(ld_fmt),
    .ld_addr(ld_addr), .rd(rd), .result(result), .memdata(memdata),
    .snpc(snpc), .out_valid(out_valid4), .out_ready(out_ready),
    .rf_wen(rf_wen4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .dnpc(dnpc4), .ld_err(ld_err4), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] ws, input logic ps,
                      input logic [2:0] fmt, input logic [2:0] addr,
                      input logic [4:0] r, input logic [31:0] res,
                      input logic [31:0] md, input logic [31:0] sn);
    in_valid = 1'b1;
    wb_sel   = ws;
    pc_sel   = ps;
    ld_fmt   = fmt;
    ld_addr  = addr;
    rd       = r;
    result   = res;
    memdata  = md;
    snpc     = sn;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wb_sel    = 2'd0;
    pc_sel    = 1'b0;
    ld_fmt    = 3'd0;
    ld_addr   = 3'd0;
    rd        = 5'd0;
    result    = '0;
    memdata   = '0;
    snpc      = '0;

    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_retired", retired, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_dnpc", dnpc, 0);
    #2 rst = 1'b0;

    // 100 back-to-back addi
    for (int i = 0; i < 100; i++) begin
      chk("tp_in_ready", in_ready, 1);
      send(2'd1, 1'b0, 3'd0, 3'd0, 5'((i % 31) + 1), 32'(i * 3 + 7),
           32'h0, 32'(i * 4));
      chk("tp_valid", out_valid, 1);
      chk("tp_wdata", rf_wdata, 64'(i * 3 + 7));
      chk("tp_waddr", rf_waddr, 64'((i % 31) + 1));
      chk("tp_wen", rf_wen, 1);
      chk("tp_retired", retired, 64'(i));
      if (i == 17) chk("wrap_cnt4", retired4, 1);
    end
    idle();
    chk("tp_drain_valid", out_valid, 0);
    chk("tp_retired_100", retired, 100);
    chk("tp_cnt4_100", retired4, 4);

    // back-pressure
    out_ready = 1'b0;
    send(2'd1, 1'b0, 3'd0, 3'd0, 5'd3, 32'h1234, 32'h0, 32'h40);
    chk("bp_valid", out_valid, 1);
    chk("bp_wen_held", rf_wen, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      send(2'd3, 1'b1, 3'd0, 3'd0, 5'd9, 32'hDEAD, 32'h0, 32'hBEEF);
      chk("bp_wdata", rf_wdata, 32'h1234);
      chk("bp_waddr", rf_waddr, 3);
      chk("bp_dnpc", dnpc, 32'h40);
      chk("bp_retired", retired, 100);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_wen", rf_wen, 1);
    idle();
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_ret", retired, 101);

    // x0 write suppressed
    send(2'd1, 1'b0, 3'd0, 3'd0, 5'd0, 32'h55, 32'h0, 32'h0);
    chk("x0_valid", out_valid, 1);
    chk("x0_wen", rf_wen, 0);
    idle();
    chk("x0_ret", retired, 102);

    // load alignment and extension
    send(2'd2, 1'b0, 3'b000, 3'd3, 5'd2, 32'h0, 32'h80FF_1234, 32'h0);
    chk("lb_data", rf_wdata, 32'hFFFF_FF80);
    chk("lb_wen", rf_wen, 1);
    send(2'd2, 1'b0, 3'b100, 3'd3, 5'd2, 32'h0, 32'h80FF_1234, 32'h0);
    chk("lbu_data", rf_wdata, 32'h0000_0080);
    send(2'd2, 1'b0, 3'b001, 3'd2, 5'd2, 32'h0, 32'h80FF_1234, 32'h0);
    chk("lh_data", rf_wdata, 32'hFFFF_80FF);
    chk("lh_err", ld_err, 0);

    // jalr
    send(2'd3, 1'b1, 3'd0, 3'd0, 5'd1, 32'h8000_0100, 32'h0,
         32'h8000_0008);
    chk("jalr_wdata", rf_wdata, 32'h8000_0008);
    chk("jalr_dnpc", dnpc, 32'h8000_0100);
    chk("jalr_wen", rf_wen, 1);

    // misaligned lw then 10 legal instructions
    send(2'd2, 1'b0, 3'b010, 3'd2, 5'd5, 32'h0, 32'h1111_2222, 32'h0);
    chk("mis_wen", rf_wen, 0);
    chk("mis_err", ld_err, 1);
    for (int i = 0; i < 10; i++) begin
      send(2'd1, 1'b0, 3'd0, 3'd0, 5'd7, 32'(i), 32'h0, 32'h0);
      chk("err_sticky", ld_err, 1);
    end
    chk("post_err_wen", rf_wen, 1);
    idle();
    chk("mis_retired", retired, 117);
    chk("mis_cnt4", retired4, 5);

    // reset while an entry is held
    out_ready = 1'b0;
    send(2'd1, 1'b0, 3'd0, 3'd0, 5'd4, 32'h77, 32'h0, 32'h0);
    chk("hold_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_retired", retired, 0);
    chk("mrst_err", ld_err, 0);
    chk("mrst_wen", rf_wen, 0);
    chk("mrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    #2 rst = 1'b0;
    idle();
    chk("mrst_after_valid", out_valid, 0);
    chk("mrst_after_ret", retired, 0);

    // ld is illegal on RV32
    send(2'd2, 1'b0, 3'b011, 3'd0, 5'd6, 32'h10, 32'hABCD, 32'h20);
    chk("ill_wen", rf_wen, 0);
    chk("ill_err", ld_err, 1);
    chk("ill_dnpc", dnpc, 32'h20);
    idle();
    chk("ill_retired", retired, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
